// File: rtl/gpr_file.sv
// gpr_file: architectural integer register file.
//   - Write-back sink: i_sys_valid/o_sys_ready handshake, carrying i_gpr_wr_en,
//     i_gpr_wr_id and i_gpr_wr_data.
//   - Two combinational read ports (i_gpr_rd_id_n -> o_gpr_rd_data_n and
//     o_gpr_rd_busy_n).
//   - Per-register pending-write scoreboard: decode marks a destination with
//     i_sb_set_en/i_sb_set_id, and retiring writebacks clear it. o_sb_stall
//     flags an issue that would overflow that register's counter.
//   - o_wb_cnt counts retired register writes.
// Optional build macro GPR_BYPASS_EN: forwards same-cycle writeback data and
// same-cycle clears to the read ports.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef GPRS_WIDTH
`define GPRS_WIDTH 5
`endif

module gpr_file #(
  parameter int unsigned DATA_WIDTH   = `DATA_WIDTH,
  parameter int unsigned GPRS_WIDTH   = `GPRS_WIDTH,
  parameter int unsigned SB_CNT_WIDTH = 2,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_sys_valid,
  output logic                  o_sys_ready,
  input  logic                  i_gpr_wr_en,
  input  logic [GPRS_WIDTH-1:0] i_gpr_wr_id,
  input  logic [DATA_WIDTH-1:0] i_gpr_wr_data,
  input  logic [GPRS_WIDTH-1:0] i_gpr_rd_id_1,
  input  logic [GPRS_WIDTH-1:0] i_gpr_rd_id_2,
  output logic [DATA_WIDTH-1:0] o_gpr_rd_data_1,
  output logic [DATA_WIDTH-1:0] o_gpr_rd_data_2,
  output logic                  o_gpr_rd_busy_1,
  output logic                  o_gpr_rd_busy_2,
  input  logic                  i_sb_set_en,
  input  logic [GPRS_WIDTH-1:0] i_sb_set_id,
  output logic                  o_sb_stall,
  output logic [CNT_WIDTH-1:0]  o_wb_cnt
);

  localparam int unsigned NUM_REGS = 2 ** GPRS_WIDTH;
  localparam logic [SB_CNT_WIDTH-1:0] SB_MAX = '1;
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
  logic [SB_CNT_WIDTH-1:0] cnt_q  [NUM_REGS];
  logic [SB_CNT_WIDTH-1:0] cnt_d  [NUM_REGS];
  logic [CNT_WIDTH-1:0]    wb_cnt_q, wb_cnt_d;

  logic wb;       // retiring write to a non-zero register
  logic sb_same;  // this cycle's retire targets the issued destination
  logic sb_set;   // accepted scoreboard issue

  assign o_sys_ready = (state_q == ST_RUN);
  assign o_wb_cnt    = wb_cnt_q;

  // Commit and scoreboard qualifiers.
  always_comb begin
    wb         = i_sys_valid && o_sys_ready && i_gpr_wr_en && (i_gpr_wr_id != '0);
    sb_same    = wb && (i_gpr_wr_id == i_sb_set_id);
    // A retire to the same id frees a slot this cycle, so a full counter may still accept.
    o_sb_stall = i_sb_set_en && (i_sb_set_id != '0) && (cnt_q[i_sb_set_id] == SB_MAX) && !sb_same;
    sb_set     = i_sb_set_en && (i_sb_set_id != '0) && !o_sb_stall;
  end

  // Next-state: ready FSM, array write, scoreboard update, retire counter.
  always_comb begin
    state_d  = state_q;
    regs_d   = regs_q;
    cnt_d    = cnt_q;
    wb_cnt_d = wb_cnt_q;
    case (state_q)
      ST_INIT: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
    if (wb) begin
      regs_d[i_gpr_wr_id] = i_gpr_wr_data;
      wb_cnt_d            = wb_cnt_q + CNT_WIDTH'(1);
    end
    // Set and clear on the same id cancel out.
    if (!(sb_set && sb_same)) begin
      if (sb_set) begin
        cnt_d[i_sb_set_id] = cnt_q[i_sb_set_id] + SB_CNT_WIDTH'(1);
      end
      // A clear with nothing pending is ignored rather than wrapping.
      if (wb && (cnt_q[i_gpr_wr_id] != '0)) begin
        cnt_d[i_gpr_wr_id] = cnt_q[i_gpr_wr_id] - SB_CNT_WIDTH'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_INIT;
      wb_cnt_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      wb_cnt_q <= wb_cnt_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  // Read ports; index 0 is hard-wired to zero and never busy.
`ifdef GPR_BYPASS_EN
  logic rd_hit_1, rd_hit_2;
`endif
  always_comb begin
    o_gpr_rd_data_1 = (i_gpr_rd_id_1 != '0) ? regs_q[i_gpr_rd_id_1] : '0;
    o_gpr_rd_data_2 = (i_gpr_rd_id_2 != '0) ? regs_q[i_gpr_rd_id_2] : '0;
    o_gpr_rd_busy_1 = (cnt_q[i_gpr_rd_id_1] != '0);
    o_gpr_rd_busy_2 = (cnt_q[i_gpr_rd_id_2] != '0);
`ifdef GPR_BYPASS_EN
    rd_hit_1 = wb && (i_gpr_wr_id == i_gpr_rd_id_1);
    rd_hit_2 = wb && (i_gpr_wr_id == i_gpr_rd_id_2);
    if (rd_hit_1) o_gpr_rd_data_1 = i_gpr_wr_data;
    if (rd_hit_2) o_gpr_rd_data_2 = i_gpr_wr_data;
    // Busy after this cycle's clear: count minus the retiring write, if any.
    o_gpr_rd_busy_1 = (cnt_q[i_gpr_rd_id_1] > SB_CNT_WIDTH'(rd_hit_1));
    o_gpr_rd_busy_2 = (cnt_q[i_gpr_rd_id_2] > SB_CNT_WIDTH'(rd_hit_2));
`endif
  end

endmodule

// File: tb/tb_gpr_file.sv
// Self-checking bench for gpr_file: directed scenarios plus randomized traffic
// checked against a behavioural model (value array, integer pending counts).
module tb_gpr_file;

  localparam int DW   = 32;
  localparam int GW   = 5;
  localparam int NR   = 32;
  localparam int MAXC = 3;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_sys_valid = 1'b0;
  logic          o_sys_ready;
  logic          i_gpr_wr_en = 1'b0;
  logic [GW-1:0] i_gpr_wr_id = '0;
  logic [DW-1:0] i_gpr_wr_data = '0;
  logic [GW-1:0] i_gpr_rd_id_1 = '0;
  logic [GW-1:0] i_gpr_rd_id_2 = '0;
  logic [DW-1:0] o_gpr_rd_data_1, o_gpr_rd_data_2;
  logic          o_gpr_rd_busy_1, o_gpr_rd_busy_2;
  logic          i_sb_set_en = 1'b0;
  logic [GW-1:0] i_sb_set_id = '0;
  logic          o_sb_stall;
  logic [31:0]   o_wb_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state.
  logic [DW-1:0] m_reg [NR];
  int            m_cnt [NR];
  logic [31:0]   m_wbcnt;
  bit            m_run;

`ifdef GPR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  gpr_file #(.DATA_WIDTH(DW), .GPRS_WIDTH(GW), .SB_CNT_WIDTH(2), .CNT_WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_sys_valid(i_sys_valid), .o_sys_ready(o_sys_ready),
    .i_gpr_wr_en(i_gpr_wr_en), .i_gpr_wr_id(i_gpr_wr_id), .i_gpr_wr_data(i_gpr_wr_data),
    .i_gpr_rd_id_1(i_gpr_rd_id_1), .i_gpr_rd_id_2(i_gpr_rd_id_2),
    .o_gpr_rd_data_1(o_gpr_rd_data_1), .o_gpr_rd_data_2(o_gpr_rd_data_2),
    .o_gpr_rd_busy_1(o_gpr_rd_busy_1), .o_gpr_rd_busy_2(o_gpr_rd_busy_2),
    .i_sb_set_en(i_sb_set_en), .i_sb_set_id(i_sb_set_id),
    .o_sb_stall(o_sb_stall), .o_wb_cnt(o_wb_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic m_reset();
    for (int i = 0; i < NR; i++) begin
      m_reg[i] = '0;
      m_cnt[i] = 0;
    end
    m_wbcnt = '0;
    m_run   = 1'b0;
  endtask

  function automatic bit m_wb();
    return i_sys_valid && m_run && i_gpr_wr_en && (i_gpr_wr_id != 0);
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [GW-1:0] rd);
    if (rd == 0) return '0;
    if (BYP && m_wb() && i_gpr_wr_id == rd) return i_gpr_wr_data;
    return m_reg[rd];
  endfunction

  function automatic bit exp_busy(input logic [GW-1:0] rd);
    int c;
    c = m_cnt[rd];
    if (BYP && m_wb() && i_gpr_wr_id == rd) c = c - 1;
    return (rd != 0) && (c > 0);
  endfunction

  function automatic bit exp_stall();
    return i_sb_set_en && (i_sb_set_id != 0) && (m_cnt[i_sb_set_id] == MAXC) &&
           !(m_wb() && i_gpr_wr_id == i_sb_set_id);
  endfunction

  // Advance the model by the rules of one clock edge, then let the DUT take it.
  task automatic tick();
    bit wb, setv;
    int nc [NR];
    wb   = m_wb();
    setv = i_sb_set_en && (i_sb_set_id != 0) && !exp_stall();
    for (int i = 0; i < NR; i++) nc[i] = m_cnt[i];
    if (setv) nc[i_sb_set_id] = nc[i_sb_set_id] + 1;
    if (wb)   nc[i_gpr_wr_id] = nc[i_gpr_wr_id] - 1;
    for (int i = 0; i < NR; i++) m_cnt[i] = (nc[i] < 0) ? 0 : nc[i];
    if (wb) begin
      m_reg[i_gpr_wr_id] = i_gpr_wr_data;
      m_wbcnt = m_wbcnt + 32'd1;
    end
    m_run = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_sys_valid = 1'b0;
    i_gpr_wr_en = 1'b0;
    i_sb_set_en = 1'b0;
  endtask

  task automatic wb_drive(input logic [GW-1:0] id, input logic [DW-1:0] d);
    i_sys_valid = 1'b1;
    i_gpr_wr_en = 1'b1;
    i_gpr_wr_id = id;
    i_gpr_wr_data = d;
  endtask

  task automatic test_reset();
    m_reset();
    #12;
    n_cmp++; if (o_sys_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%0b exp=0", o_sys_ready); end
    n_cmp++; if (o_wb_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_wbcnt got=%0d exp=0", o_wb_cnt); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    n_cmp++; if (o_sys_ready !== 1'b0) begin n_fail++; $display("FAIL init_ready got=%0b exp=0", o_sys_ready); end
    tick();
    n_cmp++; if (o_sys_ready !== 1'b1) begin n_fail++; $display("FAIL run_ready got=%0b exp=1", o_sys_ready); end
    for (int i = 0; i < NR; i++) begin
      i_gpr_rd_id_1 = GW'(i);
      i_gpr_rd_id_2 = GW'(NR - 1 - i);
      #1;
      n_cmp++;
      if (o_gpr_rd_data_1 !== '0 || o_gpr_rd_data_2 !== '0 || o_gpr_rd_busy_1 !== 1'b0 || o_gpr_rd_busy_2 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_read id=%0d got=%h/%h busy=%0b/%0b exp=0", i, o_gpr_rd_data_1, o_gpr_rd_data_2, o_gpr_rd_busy_1, o_gpr_rd_busy_2);
      end
    end
  endtask

  task automatic test_write();
    wb_drive(5'd5, 32'hDEADBEEF);
    i_gpr_rd_id_1 = 5'd5;
    tick();
    idle();
    #1;
    n_cmp++; if (o_gpr_rd_data_1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_r5 got=%h exp=deadbeef", o_gpr_rd_data_1); end
    n_cmp++; if (o_wb_cnt !== 32'd1) begin n_fail++; $display("FAIL write_cnt got=%0d exp=1", o_wb_cnt); end
    wb_drive(5'd0, 32'h1234);
    i_gpr_rd_id_1 = 5'd0;
    tick();
    idle();
    #1;
    n_cmp++; if (o_gpr_rd_data_1 !== 32'd0) begin n_fail++; $display("FAIL write_x0 got=%h exp=0", o_gpr_rd_data_1); end
    n_cmp++; if (o_wb_cnt !== 32'd1) begin n_fail++; $display("FAIL x0_cnt got=%0d exp=1", o_wb_cnt); end
  endtask

  task automatic test_sb_fill_drain();
    i_gpr_rd_id_1 = 5'd7;
    i_sb_set_en = 1'b1;
    i_sb_set_id = 5'd7;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (o_sb_stall !== 1'b0) begin n_fail++; $display("FAIL fill_stall k=%0d got=%0b exp=0", k, o_sb_stall); end
      tick();
    end
    #1;
    n_cmp++; if (o_gpr_rd_busy_1 !== 1'b1) begin n_fail++; $display("FAIL fill_busy got=%0b exp=1", o_gpr_rd_busy_1); end
    n_cmp++; if (o_sb_stall !== 1'b1) begin n_fail++; $display("FAIL fill_4th_stall got=%0b exp=1", o_sb_stall); end
    tick();
    i_sb_set_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wb_drive(5'd7, $urandom());
      #1;
      n_cmp++;
      if (o_gpr_rd_busy_1 !== ((k == 2) ? !BYP : 1'b1)) begin
        n_fail++; $display("FAIL drain_busy k=%0d got=%0b exp=%0b", k, o_gpr_rd_busy_1, (k == 2) ? !BYP : 1'b1);
      end
      tick();
    end
    idle();
    #1;
    n_cmp++; if (o_gpr_rd_busy_1 !== 1'b0) begin n_fail++; $display("FAIL drain_done got=%0b exp=0", o_gpr_rd_busy_1); end
    n_cmp++; if (o_wb_cnt !== 32'd4) begin n_fail++; $display("FAIL drain_cnt got=%0d exp=4", o_wb_cnt); end
  endtask

  task automatic test_same_cycle();
    i_gpr_rd_id_1 = 5'd9;
    i_sb_set_en = 1'b1;
    i_sb_set_id = 5'd9;
    tick();
    wb_drive(5'd9, 32'h0909_0909);
    tick();
    idle();
    #1;
    n_cmp++; if (o_gpr_rd_busy_1 !== 1'b1) begin n_fail++; $display("FAIL setclr_busy got=%0b exp=1", o_gpr_rd_busy_1); end
    i_sb_set_en = 1'b1;
    tick();
    tick();
    wb_drive(5'd9, 32'h1111_2222);
    #1;
    n_cmp++; if (o_sb_stall !== 1'b0) begin n_fail++; $display("FAIL full_setclr_stall got=%0b exp=0", o_sb_stall); end
    tick();
    i_sys_valid = 1'b0;
    #1;
    n_cmp++; if (o_sb_stall !== 1'b1) begin n_fail++; $display("FAIL full_still_stall got=%0b exp=1", o_sb_stall); end
    i_sb_set_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wb_drive(5'd9, 32'h9);
      tick();
    end
    idle();
    #1;
    n_cmp++; if (o_gpr_rd_busy_1 !== 1'b0) begin n_fail++; $display("FAIL r9_drained got=%0b exp=0", o_gpr_rd_busy_1); end
  endtask

  task automatic test_bypass();
    i_gpr_rd_id_2 = 5'd3;
    i_sb_set_en = 1'b1;
    i_sb_set_id = 5'd3;
    tick();
    i_sb_set_en = 1'b0;
    wb_drive(5'd3, 32'hA5A5A5A5);
    #1;
    n_cmp++; if (o_gpr_rd_data_2 !== (BYP ? 32'hA5A5A5A5 : 32'h0)) begin n_fail++; $display("FAIL raw_data got=%h exp=%h", o_gpr_rd_data_2, BYP ? 32'hA5A5A5A5 : 32'h0); end
    n_cmp++; if (o_gpr_rd_busy_2 !== !BYP) begin n_fail++; $display("FAIL raw_busy got=%0b exp=%0b", o_gpr_rd_busy_2, !BYP); end
    tick();
    idle();
    #1;
    n_cmp++; if (o_gpr_rd_data_2 !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL raw_next got=%h exp=a5a5a5a5", o_gpr_rd_data_2); end
    n_cmp++; if (o_gpr_rd_busy_2 !== 1'b0) begin n_fail++; $display("FAIL raw_next_busy got=%0b exp=0", o_gpr_rd_busy_2); end
  endtask

  task automatic test_reset_mid();
    i_gpr_rd_id_1 = 5'd4;
    wb_drive(5'd4, 32'h55);
    tick();
    idle();
    i_sb_set_en = 1'b1;
    i_sb_set_id = 5'd4;
    tick();
    tick();
    idle();
    #1;
    n_cmp++; if (o_gpr_rd_data_1 !== 32'h55 || o_gpr_rd_busy_1 !== 1'b1) begin n_fail++; $display("FAIL pre_rst got=%h/%0b exp=55/1", o_gpr_rd_data_1, o_gpr_rd_busy_1); end
    #1;
    i_rst_n = 1'b0;
    m_reset();
    #1;
    n_cmp++;
    if (o_gpr_rd_data_1 !== '0 || o_gpr_rd_busy_1 !== 1'b0 || o_sys_ready !== 1'b0 || o_wb_cnt !== '0) begin
      n_fail++; $display("FAIL mid_rst got=%h/%0b rdy=%0b cnt=%0d exp=0", o_gpr_rd_data_1, o_gpr_rd_busy_1, o_sys_ready, o_wb_cnt);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    wb_drive(5'd4, 32'h77);
    #1;
    n_cmp++; if (o_sys_ready !== 1'b0) begin n_fail++; $display("FAIL reinit_ready got=%0b exp=0", o_sys_ready); end
    tick();
    idle();
    #1;
    n_cmp++;
    if (o_gpr_rd_data_1 !== '0 || o_wb_cnt !== '0 || o_sys_ready !== 1'b1) begin
      n_fail++; $display("FAIL init_drop got=%h cnt=%0d rdy=%0b exp=0/0/1", o_gpr_rd_data_1, o_wb_cnt, o_sys_ready);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] ed1, ed2;
    bit eb1, eb2, es;
    for (int n = 0; n < 400; n++) begin
      i_sys_valid   = ($urandom_range(0, 3) != 0);
      i_gpr_wr_en   = ($urandom_range(0, 7) != 0);
      i_gpr_wr_id   = GW'($urandom_range(0, 7));
      i_gpr_wr_data = $urandom();
      i_gpr_rd_id_1 = GW'($urandom_range(0, 7));
      i_gpr_rd_id_2 = GW'($urandom_range(0, 31));
      i_sb_set_en   = ($urandom_range(0, 1) != 0);
      i_sb_set_id   = GW'($urandom_range(0, 7));
      #1;
      ed1 = exp_data(i_gpr_rd_id_1);
      ed2 = exp_data(i_gpr_rd_id_2);
      eb1 = exp_busy(i_gpr_rd_id_1);
      eb2 = exp_busy(i_gpr_rd_id_2);
      es  = exp_stall();
      n_cmp++;
      if (o_gpr_rd_data_1 !== ed1 || o_gpr_rd_data_2 !== ed2 || o_gpr_rd_busy_1 !== eb1 ||
          o_gpr_rd_busy_2 !== eb2 || o_sb_stall !== es || o_wb_cnt !== m_wbcnt || o_sys_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rand n=%0d got d=%h/%h b=%0b/%0b st=%0b c=%0d exp d=%h/%h b=%0b/%0b st=%0b c=%0d",
                 n, o_gpr_rd_data_1, o_gpr_rd_data_2, o_gpr_rd_busy_1, o_gpr_rd_busy_2, o_sb_stall, o_wb_cnt,
                 ed1, ed2, eb1, eb2, es, m_wbcnt);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write();
    test_sb_fill_drain();
    test_same_cycle();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
